// File: rtl/fht_unload_pkg.sv
// rtl/fht_unload_pkg.sv - shared constants, state encoding and FIFO entry layout for fht_unload
//
// Purpose: items shared by fht_unload and its output FIFO.
//   n_pts()       : number of transform points, 4 banks of 2^A_BIT words.
//   state_t       : unload controller states.
//   entry_width() : width of one FIFO entry packed as {data, index, last}.
// Ports: none (package).
package fht_unload_pkg;

  localparam int A_BIT_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // N_PTS = 4 << A_BIT
  function automatic int n_pts(input int a_bit);
    return 4 << a_bit;
  endfunction

  // {data[D_BIT], index[A_BIT+2], last[1]}
  function automatic int entry_width(input int d_bit, input int a_bit);
    return d_bit + a_bit + 3;
  endfunction

endpackage

// File: rtl/fht_unload_fifo.sv
// rtl/fht_unload_fifo.sv - synchronous FIFO with occupancy count and flush
//
// Purpose: small output buffer that absorbs RAM read latency under backpressure.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   flush       : empties the FIFO at the next edge (wins over push/pop)
//   push, push_data : write side
//   pop         : read side, advances the head when not empty
//   head        : current head entry (meaningful only when !empty)
//   empty       : no entries held
//   count       : number of entries held, 0..DEPTH
module fht_unload_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fht_unload.sv
// rtl/fht_unload.sv - streams the finished FHT result out of the four RAM banks in index order
//
// Purpose: after the FHT controller reports ready, reads the four working banks
// in natural index order (bank 0 fully, then 1, 2, 3), absorbs the RAM read
// latency and presents samples on a valid/ready stream with full backpressure.
// Ports:
//   iCLK, iRESET          : clock, synchronous active-low reset
//   iSTART, iFHT_RDY      : start request, controller ready (abort when it falls)
//   iBANK_SEL / oBANK_SET : bank set holding the result, latched at start
//   oADDR_RD, oRD_EN      : common read address, one-hot bank read enable
//   iDATA_0..iDATA_3      : bank read data, RD_LAT cycles after oRD_EN
//   oDATA, oINDEX, oLAST, oVALID, iREADY : output sample stream
//   oBUSY, oDONE, oABORT  : status
module fht_unload
  import fht_unload_pkg::*;
#(
  parameter int A_BIT  = A_BIT_DEFAULT,
  parameter int D_BIT  = 16,
  parameter int RD_LAT = 2,
  parameter int SCALE  = 0
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iSTART,
  input  logic               iFHT_RDY,
  input  logic               iBANK_SEL,
  output logic               oBANK_SET,
  output logic [A_BIT-1:0]   oADDR_RD,
  output logic [3:0]         oRD_EN,
  input  logic [D_BIT-1:0]   iDATA_0,
  input  logic [D_BIT-1:0]   iDATA_1,
  input  logic [D_BIT-1:0]   iDATA_2,
  input  logic [D_BIT-1:0]   iDATA_3,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT+1:0]   oINDEX,
  output logic               oVALID,
  input  logic               iREADY,
  output logic               oLAST,
  output logic               oBUSY,
  output logic               oDONE,
  output logic               oABORT
);

  localparam int N_PTS = n_pts(A_BIT);
  localparam int IW    = A_BIT + 2;
  localparam int DEPTH = RD_LAT + 2;
  localparam int EW    = entry_width(D_BIT, A_BIT);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PTS - 1);

  state_t            state;
  state_t            state_nxt;
  logic [IW-1:0]     rd_idx;
  logic              bank_set;
  logic              abort_q;
  logic              last_xfer;
  logic              abort_now;
  logic              start_ok;
  logic              issue;
  logic              credit_ok;

  logic [RD_LAT-1:0] pipe_vld;
  logic [IW-1:0]     pipe_idx [RD_LAT];
  logic [CW-1:0]     inflight;

  logic [IW-1:0]     exit_idx;
  logic [1:0]        exit_bank;
  logic [D_BIT-1:0]  bank_word;
  logic [D_BIT-1:0]  scaled;

  logic [EW-1:0]     push_entry;
  logic [EW-1:0]     head_entry;
  logic              push;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;

  logic [D_BIT-1:0]  head_data;
  logic [IW-1:0]     head_idx;
  logic              head_last;

  // Reads still travelling through the RAM latency pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_vld[i]);
    end
  end

  // Credit uses only registered occupancy, so iREADY never reaches oRD_EN.
  // Every issued read is guaranteed a FIFO slot when its data arrives.
  assign credit_ok = (int'(fifo_count) + int'(inflight) + 1) <= DEPTH;
  assign issue     = (state == READ) && credit_ok;
  assign start_ok  = iSTART && iFHT_RDY;

  always_comb begin
    state_nxt = state;
    abort_now = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (!iFHT_RDY) begin
          state_nxt = IDLE;
          abort_now = 1'b1;
        end else if (issue && (rd_idx == LAST_IDX)) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!iFHT_RDY) begin
          state_nxt = IDLE;
          abort_now = 1'b1;
        end else if (fifo_empty && (inflight == '0) && last_xfer) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state     <= IDLE;
      rd_idx    <= '0;
      bank_set  <= 1'b0;
      abort_q   <= 1'b0;
      last_xfer <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_now;
      if ((state == IDLE) && start_ok) begin
        bank_set  <= iBANK_SEL;
        rd_idx    <= '0;
        last_xfer <= 1'b0;
      end else if (abort_now) begin
        rd_idx <= '0;
      end else if (issue) begin
        // IW bits hold exactly N_PTS indices, so k wraps to 0 after N-1.
        rd_idx <= rd_idx + 1'b1;
      end
      if (pop && head_last) begin
        last_xfer <= 1'b1;
      end
    end
  end

  // Fixed-latency pipeline: each stage is one cycle of RAM read latency.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= issue && !abort_now;
      pipe_idx[0] <= rd_idx;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1] && !abort_now;
        pipe_idx[i] <= pipe_idx[i-1];
      end
    end
  end

  assign exit_idx  = pipe_idx[RD_LAT-1];
  assign exit_bank = exit_idx[IW-1 -: 2];

  always_comb begin
    bank_word = iDATA_0;
    case (exit_bank)
      2'd1:    bank_word = iDATA_1;
      2'd2:    bank_word = iDATA_2;
      2'd3:    bank_word = iDATA_3;
      default: bank_word = iDATA_0;
    endcase
  end

  assign scaled     = D_BIT'($signed(bank_word) >>> SCALE);
  assign push       = pipe_vld[RD_LAT-1];
  assign push_entry = {scaled, exit_idx, (exit_idx == LAST_IDX)};
  assign pop        = !fifo_empty && iREADY;

  fht_unload_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk       (iCLK),
    .resetn    (iRESET),
    .flush     (abort_now),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_data = head_entry[EW-1 -: D_BIT];
  assign head_idx  = head_entry[IW:1];
  assign head_last = head_entry[0];

  // Head fields are gated so the stream reads as zero while nothing is held.
  assign oVALID    = !fifo_empty;
  assign oDATA     = fifo_empty ? '0 : head_data;
  assign oINDEX    = fifo_empty ? '0 : head_idx;
  assign oLAST     = !fifo_empty && head_last;

  assign oRD_EN    = issue ? (4'b0001 << rd_idx[IW-1 -: 2]) : 4'b0000;
  assign oADDR_RD  = rd_idx[A_BIT-1:0];
  assign oBANK_SET = bank_set;
  assign oBUSY     = (state == READ) || (state == DRAIN);
  assign oDONE     = (state == DONE);
  assign oABORT    = abort_q;

endmodule
